// File: rtl/flappy_pkg.sv
// Shared game-world constants, controller state encodings and coordinate helpers.
// Imported by the world kinematics block and the game-control FSM.
`timescale 1ns/1ps
package flappy_pkg;

  localparam int COORD_W     = 10;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BIRD_HALF   = 10;
  localparam int PIPE_HALF_W = 50;
  localparam int GAP_H       = 150;
  localparam int FALL_LIMIT  = 1000;
  localparam int VEL_W       = 6;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [2:0] {
    CTRL_I    = 3'b001,
    CTRL_GAME = 3'b010,
    CTRL_END  = 3'b100
  } ctrl_state_e;

  // Saturate a signed intermediate onto the 10-bit screen coordinate range.
  function automatic coord_t clamp_coord(input logic signed [11:0] v);
    coord_t r;
    if (v < 12'sd0) begin
      r = '0;
    end else if (v > 12'sd1023) begin
      r = '1;
    end else begin
      r = v[COORD_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/flappy_world_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with enable and synchronous reset to seed.
`timescale 1ns/1ps
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        fb;

  assign fb = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = {state_q[14:0], fb};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/flappy_world.sv
// Game-world kinematics: bird height/velocity and two scrolling pipes, updated once per physics tick.
// Positions register on the edge that ends a Tick cycle; the controller state selects init/run/freeze.
`timescale 1ns/1ps
module flappy_world
  import flappy_pkg::*;
#(
  parameter int TICK_DIV     = 833333,
  parameter int BIRD_X       = 160,
  parameter int BIRD_Y0      = 240,
  parameter int GRAVITY      = 1,
  parameter int FLAP_VEL     = -8,
  parameter int VMAX         = 10,
  parameter int PIPE_SPEED   = 2,
  parameter int PIPE_X0      = 640,
  parameter int PIPE_SPACING = 360,
  parameter int GAP_MIN      = 40,
  parameter int GAP_Y0       = 200
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               q_I,
  input  logic               q_EN,
  input  logic               q_End,
  input  logic               Flap,
  output logic [COORD_W-1:0] XBird,
  output logic [COORD_W-1:0] YBird,
  output logic [COORD_W-1:0] XPipe1,
  output logic [COORD_W-1:0] YPipe1,
  output logic [COORD_W-1:0] XPipe2,
  output logic [COORD_W-1:0] YPipe2,
  output logic               Tick
);

  localparam int                CNT_W    = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam coord_t            Y0       = coord_t'(BIRD_Y0);
  localparam coord_t            X1_0     = coord_t'(PIPE_X0);
  localparam coord_t            X2_0     = coord_t'(PIPE_X0 + PIPE_SPACING);
  localparam coord_t            GAP0     = coord_t'(GAP_Y0);
  localparam coord_t            SPEED    = coord_t'(PIPE_SPEED);
  localparam vel_t              FLAP_V   = vel_t'(FLAP_VEL);
  localparam vel_t              VMAX_V   = vel_t'(VMAX);
  localparam logic signed [6:0] VMAX_W   = 7'(VMAX);
  localparam logic signed [6:0] GRAV_W   = 7'(GRAVITY);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  coord_t           ybird_q, ybird_d;
  coord_t           xp1_q, xp1_d, yp1_q, yp1_d;
  coord_t           xp2_q, xp2_d, yp2_q, yp2_d;
  vel_t             vel_q, vel_d;
  logic             pend_q, pend_d;
  logic             hist_q;

  logic [15:0]         lfsr_state;
  logic                lfsr_unused_hi;
  ctrl_state_e         ctrl;
  logic                flap_rise;
  logic signed [6:0]   vel_inc;
  vel_t                vel_fall, vel_tick;
  logic signed [11:0]  y_sum;
  coord_t              gap_new, xp1_step, xp2_step;
  logic                xp1_wrap, xp2_wrap;

  lfsr16 #(.SEED(16'hACE1)) u_lfsr (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .en_i    (1'b1),
    .state_o (lfsr_state)
  );

  assign lfsr_unused_hi = ^lfsr_state[15:8];

  assign ctrl      = ctrl_state_e'({q_End, q_EN, q_I});
  assign flap_rise = Flap & ~hist_q;

  assign vel_inc  = 7'(vel_q) + GRAV_W;
  assign vel_fall = (vel_inc > VMAX_W) ? VMAX_V : vel_inc[VEL_W-1:0];
  assign vel_tick = (pend_q | flap_rise) ? FLAP_V : vel_fall;
  assign y_sum    = $signed({2'b00, ybird_q}) + 12'(vel_tick);

  // Pipe 1 respawns behind pipe 2's old X; pipe 2 respawns behind pipe 1's new X.
  assign gap_new  = coord_t'(GAP_MIN) + coord_t'(lfsr_state[7:0]);
  assign xp1_wrap = (xp1_q <= SPEED);
  assign xp2_wrap = (xp2_q <= SPEED);
  assign xp1_step = xp1_wrap ? xp2_q + coord_t'(PIPE_SPACING - PIPE_SPEED) : xp1_q - SPEED;
  assign xp2_step = xp2_wrap ? xp1_step + coord_t'(PIPE_SPACING) : xp2_q - SPEED;

  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d  = (cnt_q == CNT_LAST);
    ybird_d = ybird_q;
    xp1_d   = xp1_q;
    yp1_d   = yp1_q;
    xp2_d   = xp2_q;
    yp2_d   = yp2_q;
    vel_d   = vel_q;
    pend_d  = pend_q;
    case (ctrl)
      CTRL_I: begin
        ybird_d = Y0;
        xp1_d   = X1_0;
        yp1_d   = GAP0;
        xp2_d   = X2_0;
        yp2_d   = GAP0;
        vel_d   = '0;
        pend_d  = 1'b0;
      end
      CTRL_GAME: begin
        if (tick_q) begin
          vel_d   = vel_tick;
          pend_d  = 1'b0;
          ybird_d = clamp_coord(y_sum);
          xp1_d   = xp1_step;
          xp2_d   = xp2_step;
          if (xp1_wrap) yp1_d = gap_new;
          if (xp2_wrap) yp2_d = gap_new;
        end else begin
          pend_d = pend_q | flap_rise;
        end
      end
      default: begin
        pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      ybird_q <= Y0;
      xp1_q   <= X1_0;
      yp1_q   <= GAP0;
      xp2_q   <= X2_0;
      yp2_q   <= GAP0;
      vel_q   <= '0;
      pend_q  <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      ybird_q <= ybird_d;
      xp1_q   <= xp1_d;
      yp1_q   <= yp1_d;
      xp2_q   <= xp2_d;
      yp2_q   <= yp2_d;
      vel_q   <= vel_d;
      pend_q  <= pend_d;
      hist_q  <= Flap;
    end
  end

  assign XBird  = coord_t'(BIRD_X);
  assign YBird  = ybird_q;
  assign XPipe1 = xp1_q;
  assign YPipe1 = yp1_q;
  assign XPipe2 = xp2_q;
  assign YPipe2 = yp2_q;
  assign Tick   = tick_q;

endmodule

// File: tb/tb_flappy_world.sv
// Randomized and directed bench for flappy_world against a cycle-level integer reference model.
`timescale 1ns/1ps
module tb_flappy_world;

  localparam int TD = 4;

  logic       Clk = 1'b0;
  logic       Reset, q_I, q_EN, q_End, Flap;
  logic [9:0] XBird, YBird, XPipe1, YPipe1, XPipe2, YPipe2;
  logic       Tick;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state (plain integers).
  int m_yb, m_x1, m_y1, m_x2, m_y2, m_vel, m_cnt, m_lfsr;
  bit m_pend, m_hist, m_tick, m_upd;

  flappy_world #(.TICK_DIV(TD)) dut (
    .Clk(Clk), .Reset(Reset), .q_I(q_I), .q_EN(q_EN), .q_End(q_End), .Flap(Flap),
    .XBird(XBird), .YBird(YBird), .XPipe1(XPipe1), .YPipe1(YPipe1),
    .XPipe2(XPipe2), .YPipe2(YPipe2), .Tick(Tick)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 16'hFFFF;
  endfunction

  task automatic model_init_pos();
    m_yb = 240; m_x1 = 640; m_x2 = 1000; m_y1 = 200; m_y2 = 200;
    m_vel = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    int st, ny, nx1, nx2, gap;
    bit rise;
    m_upd = 0;
    if (Reset) begin
      model_init_pos();
      m_hist = 0; m_cnt = 0; m_tick = 0; m_lfsr = 16'hACE1;
      return;
    end
    st   = {q_End, q_EN, q_I};
    rise = Flap && !m_hist;
    if (st == 1) begin
      model_init_pos();
    end else if (st == 2) begin
      if (m_tick) begin
        m_upd = 1;
        if (m_pend || rise) m_vel = -8;
        else m_vel = (m_vel + 1 > 10) ? 10 : m_vel + 1;
        m_pend = 0;
        ny = m_yb + m_vel;
        m_yb = (ny < 0) ? 0 : (ny > 1023) ? 1023 : ny;
        gap = 40 + (m_lfsr & 255);
        nx1 = (m_x1 <= 2) ? ((m_x2 + 358) & 1023) : m_x1 - 2;
        nx2 = (m_x2 <= 2) ? ((nx1 + 360) & 1023) : m_x2 - 2;
        if (m_x1 <= 2) m_y1 = gap;
        if (m_x2 <= 2) m_y2 = gap;
        m_x1 = nx1; m_x2 = nx2;
      end else begin
        m_pend = m_pend || rise;
      end
    end else begin
      m_pend = 0;
    end
    m_hist = Flap;
    m_tick = (m_cnt == TD - 1);
    m_cnt  = (m_cnt + 1) % TD;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic compare_all();
    check("XBird", XBird, 160);
    check("YBird", YBird, m_yb);
    check("XPipe1", XPipe1, m_x1);
    check("YPipe1", YPipe1, m_y1);
    check("XPipe2", XPipe2, m_x2);
    check("YPipe2", YPipe2, m_y2);
    check("Tick", Tick, m_tick);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_updates(input int n);
    repeat (n) begin
      do step(); while (!m_upd);
    end
  endtask

  task automatic set_state(input logic [2:0] s);
    {q_End, q_EN, q_I} = s;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_y"}, YBird, 240);
    check({tag, "_x1"}, XPipe1, 640);
    check({tag, "_x2"}, XPipe2, 1000);
    check({tag, "_y1"}, YPipe1, 200);
    check({tag, "_y2"}, YPipe2, 200);
  endtask

  initial begin
    int guard, snap_y, snap_x1, snap_y2;
    int exp_y[3]  = '{241, 243, 246};
    int exp_x1[3] = '{638, 636, 634};
    int exp_x2[3] = '{998, 996, 994};
    logic [2:0] st;

    Reset = 1'b1; Flap = 1'b0; set_state(3'b001);
    step();
    Reset = 1'b0;
    check_reset_vals("rst");
    check("rst_tick", Tick, 0);

    // Free fall, no flap
    set_state(3'b010);
    for (int k = 0; k < 3; k++) begin
      run_updates(1);
      check("fall_y", YBird, exp_y[k]);
      check("fall_x1", XPipe1, exp_x1[k]);
      check("fall_x2", XPipe2, exp_x2[k]);
    end

    // Held flap gives exactly one impulse
    Flap = 1'b1;
    run_updates(1);
    check("flap_y1", YBird, 238);
    run_updates(1);
    check("flap_y2", YBird, 231);
    run_updates(8);
    check("flap_hold_y", YBird, 211);
    Flap = 1'b0;

    // Run until pipe 1 sits at X=2, then check the respawn tick
    guard = 0;
    while (m_x1 != 2 && guard < 400) begin
      Flap = ($urandom_range(0, 3) == 0);
      run_updates(1);
      guard++;
    end
    check("respawn_reached", guard < 400, 1);
    check("pre_x2", XPipe2, 362);
    snap_y2 = m_y2;
    run_updates(1);
    check("resp_x1", XPipe1, 720);
    check("resp_x2", XPipe2, 360);
    check("resp_gap_rng", (YPipe1 >= 40 && YPipe1 <= 295), 1);
    check("resp_y2_kept", YPipe2, snap_y2);

    // Flap every tick to hit the ceiling, then fall to the floor
    repeat (130) begin
      Flap = 1'b1; step(); Flap = 1'b0;
      run_updates(1);
    end
    check("ceiling_y", YBird, 0);
    repeat (150) run_updates(1);
    check("floor_y", YBird, 1023);

    // END freezes everything, edges ignored
    run_updates(3);
    snap_y = m_yb; snap_x1 = m_x1;
    set_state(3'b100);
    for (int i = 0; i < 5 * TD; i++) begin
      Flap = i[0];
      step();
    end
    Flap = 1'b0;
    check("end_y", YBird, snap_y);
    check("end_x1", XPipe1, snap_x1);

    set_state(3'b001);
    step();
    check_reset_vals("idle");

    // Non-one-hot state freezes
    set_state(3'b010);
    run_updates(3);
    snap_y = m_yb; snap_x1 = m_x1;
    set_state(3'b000); repeat (2 * TD) step();
    set_state(3'b011); repeat (2 * TD) step();
    check("none_y", YBird, snap_y);
    check("multi_x1", XPipe1, snap_x1);

    // Reset between ticks mid-game
    set_state(3'b010);
    run_updates(2);
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_reset_vals("midrst");
    check("midrst_tick", Tick, 0);

    // Randomized phase
    st = 3'b010;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: st = 3'b010;
          5, 6:          st = 3'b001;
          7:             st = 3'b100;
          default:       st = 3'($urandom_range(0, 7));
        endcase
      end
      set_state(st);
      Flap  = ($urandom_range(0, 5) == 0);
      Reset = ($urandom_range(0, 499) == 0);
      step();
    end
    Reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
